circuito_jogo_param: RTL and testbench

CIRCUITO_JOGO_PARAM -- requirements
Module: circuito_jogo_param

---
 rtl/circuito_jogo_param.sv | 163 ++++++++++++++++
 tb/tb_circuito_jogo_param.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/circuito_jogo_param.sv
// Sequence-memory game controller: the player repeats a growing button sequence.
// Optional per-action timeout is enabled by defining JOGO_TIMEOUT_EN.
module circuito_jogo_param #(
  parameter int N_BOTOES       = 4,
  parameter int N_RODADAS      = 16,
  parameter int TIMEOUT_CICLOS = 3000,
  localparam int AW            = $clog2(N_RODADAS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic                ganhou,
  output logic                perdeu,
  output logic                pronto,
  output logic [3:0]          db_estado,
  output logic [AW-1:0]       db_rodada,
  output logic [AW-1:0]       db_contagem,
  output logic                db_igual,
  output logic                db_timeout
);

  typedef enum logic [3:0] {
    st_inicial        = 4'h0,
    st_preparacao     = 4'h1,
    st_espera_jogada  = 4'h2,
    st_compara        = 4'h3,
    st_proxima_jogada = 4'h4,
    st_espera_nova    = 4'h5,
    st_grava          = 4'h6,
    st_proxima_rodada = 4'h7,
    st_fim_ganhou     = 4'hA,
    st_fim_timeout    = 4'hD,
    st_fim_perdeu     = 4'hE
  } estado_t;

  estado_t             estado, estado_next;
  logic [AW-1:0]       rodada, contagem;
  logic [N_BOTOES-1:0] jogada_reg;
  logic                algum_prev;
  logic                jogada, expira, aguardando;
  logic                limpa, inc_contagem, inc_rodada, grava_en;
  logic                igual_mem, um_quente;
  logic [N_BOTOES-1:0] mem [N_RODADAS];

  assign jogada     = (|botoes) & ~algum_prev;
  assign aguardando = (estado == st_espera_jogada) || (estado == st_espera_nova);
  assign igual_mem  = (jogada_reg == mem[contagem]);
  assign um_quente  = (jogada_reg != '0) && ((jogada_reg & (jogada_reg - 1'b1)) == '0);

`ifdef JOGO_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  logic [TW-1:0] timer;
  logic          timeout_flag;

  assign expira     = aguardando && (timer == TW'(TIMEOUT_CICLOS - 1));
  assign db_timeout = timeout_flag;

  // Timer restarts on any state change (covers every state entry) and on each jogada.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer        <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (limpa || (estado_next != estado) || jogada) timer <= '0;
      else if (aguardando)                            timer <= timer + 1'b1;
      if (limpa)       timeout_flag <= 1'b0;
      else if (expira) timeout_flag <= 1'b1;
    end
  end
`else
  assign expira     = 1'b0;
  assign db_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= st_inicial;
      rodada     <= '0;
      contagem   <= '0;
      jogada_reg <= '0;
      algum_prev <= 1'b0;
    end else begin
      estado     <= estado_next;
      algum_prev <= |botoes;
      if (jogada && !expira) jogada_reg <= botoes;
      if (limpa) begin
        rodada   <= '0;
        contagem <= '0;
      end else if (inc_rodada) begin
        rodada   <= rodada + 1'b1;
        contagem <= '0;
      end else if (inc_contagem) begin
        contagem <= contagem + 1'b1;
      end
    end
  end

  // Sequence memory intentionally keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (grava_en) mem[rodada] <= jogada_reg;
  end

  always_comb begin
    estado_next  = estado;
    limpa        = 1'b0;
    inc_contagem = 1'b0;
    inc_rodada   = 1'b0;
    grava_en     = 1'b0;
    case (estado)
      st_inicial:        if (jogar) estado_next = st_preparacao;
      // Round counter is cleared here, so the game always opens by recording a new jogada.
      st_preparacao: begin
        limpa       = 1'b1;
        estado_next = st_espera_nova;
      end
      st_espera_jogada: begin
        if (expira)      estado_next = st_fim_timeout;
        else if (jogada) estado_next = st_compara;
      end
      st_compara: begin
        if (igual_mem && um_quente)
          estado_next = (contagem == rodada - 1'b1) ? st_espera_nova : st_proxima_jogada;
        else
          estado_next = st_fim_perdeu;
      end
      st_proxima_jogada: begin
        inc_contagem = 1'b1;
        estado_next  = st_espera_jogada;
      end
      st_espera_nova: begin
        if (expira)      estado_next = st_fim_timeout;
        else if (jogada) estado_next = st_grava;
      end
      st_grava: begin
        if (um_quente) begin
          grava_en    = 1'b1;
          estado_next = (rodada == AW'(N_RODADAS - 1)) ? st_fim_ganhou : st_proxima_rodada;
        end else begin
          estado_next = st_fim_perdeu;
        end
      end
      st_proxima_rodada: begin
        inc_rodada  = 1'b1;
        estado_next = st_espera_jogada;
      end
      st_fim_ganhou, st_fim_timeout, st_fim_perdeu:
        if (jogar) estado_next = st_preparacao;
      default: estado_next = st_inicial;
    endcase
  end

  assign leds        = jogada_reg;
  assign ganhou      = (estado == st_fim_ganhou);
  assign perdeu      = (estado == st_fim_perdeu) || (estado == st_fim_timeout);
  assign pronto      = ganhou || perdeu;
  assign db_estado   = estado;
  assign db_rodada   = rodada;
  assign db_contagem = contagem;
  assign db_igual    = (estado == st_compara) && igual_mem && um_quente;

endmodule

// File: tb/tb_circuito_jogo_param.sv
// Directed bench for circuito_jogo_param (N_RODADAS=4, TIMEOUT_CICLOS=50).
// Expected timeout behaviour follows whether JOGO_TIMEOUT_EN is defined.
module tb_circuito_jogo_param;
  localparam int NB = 4;
  localparam int NR = 4;
  localparam int AW = $clog2(NR);

  logic          clock = 1'b0;
  logic          reset;
  logic          jogar;
  logic [NB-1:0] botoes;
  logic [NB-1:0] leds;
  logic          ganhou, perdeu, pronto;
  logic [3:0]    db_estado;
  logic [AW-1:0] db_rodada, db_contagem;
  logic          db_igual, db_timeout;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] st_seen;
  logic       igual_seen;

  circuito_jogo_param #(.N_BOTOES(NB), .N_RODADAS(NR), .TIMEOUT_CICLOS(50)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes), .leds(leds),
    .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .db_estado(db_estado),
    .db_rodada(db_rodada), .db_contagem(db_contagem), .db_igual(db_igual),
    .db_timeout(db_timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Hold a pattern for two cycles, release for two; records state/db_igual one edge after the press.
  task automatic press(input logic [NB-1:0] pat);
    botoes = pat;
    @(posedge clock);
    #2;
    st_seen    = db_estado;
    igual_seen = db_igual;
    @(posedge clock);
    #1;
    botoes = '0;
    tick(2);
  endtask

  task automatic new_game();
    jogar = 1'b1;
    tick(1);
    jogar = 1'b0;
    tick(1);
    check("new_game_estado", db_estado, 4'h5);
    check("new_game_flags", {ganhou, perdeu, pronto, db_timeout}, 4'b0000);
    check("new_game_rodada", db_rodada, 0);
  endtask

  initial begin
    reset = 1'b0; jogar = 1'b0; botoes = '0;
    #12;
    check("reset_estado", db_estado, 4'h0);
    check("reset_outs", {leds, ganhou, perdeu, pronto, db_igual, db_timeout}, 0);
    @(posedge clock); #1 reset = 1'b1;
    tick(1);
    check("idle_estado", db_estado, 4'h0);

    // Start with jogar held for ten cycles
    jogar = 1'b1;
    tick(1);
    check("start_prep", db_estado, 4'h1);
    tick(1);
    check("start_espera_nova", db_estado, 4'h5);
    tick(8);
    check("jogar_held_estado", db_estado, 4'h5);
    check("jogar_held_flags", {ganhou, perdeu, pronto}, 3'b000);
    jogar = 1'b0;

    // Full winning game
    for (int r = 0; r < NR; r++) begin
      for (int i = 0; i < r; i++) begin
        press(NB'(1) << i);
        check("win_compara_estado", st_seen, 4'h3);
        check("win_compara_igual", igual_seen, 1'b1);
      end
      press(NB'(1) << r);
      check("win_grava_estado", st_seen, 4'h6);
      check("win_leds", leds, NB'(1) << r);
      if (r < NR - 1) begin
        check("win_round_estado", db_estado, 4'h2);
        check("win_round_rodada", db_rodada, r + 1);
      end
    end
    check("win_estado", db_estado, 4'hA);
    check("win_flags", {ganhou, perdeu, pronto}, 3'b101);

    // Wrong jogada in round 2
    new_game();
    press(4'b0001); press(4'b0001); press(4'b0010);
    check("lose_rodada2", db_rodada, 2);
    press(4'b0001);
    check("lose_first_igual", igual_seen, 1'b1);
    press(4'b0100);
    check("lose_compara_estado", st_seen, 4'h3);
    check("lose_compara_igual", igual_seen, 1'b0);
    check("lose_estado", db_estado, 4'hE);
    check("lose_flags", {ganhou, perdeu, pronto}, 3'b011);

    // Non-one-hot new jogada
    new_game();
    press(4'b0001); press(4'b0001);
    check("nonhot_pre_estado", db_estado, 4'h5);
    press(4'b0011);
    check("nonhot_grava_estado", st_seen, 4'h6);
    check("nonhot_estado", db_estado, 4'hE);
    check("nonhot_leds", leds, 4'b0011);

    // Non-one-hot jogada against stored sequence
    new_game();
    press(4'b0001);
    press(4'b0011);
    check("nonhot_cmp_igual", igual_seen, 1'b0);
    check("nonhot_cmp_estado", db_estado, 4'hE);

    // jogar ignored mid-game, then idle in espera_jogada
    new_game();
    press(4'b0001);
    jogar = 1'b1;
    tick(3);
    jogar = 1'b0;
    check("jogar_ignored", db_estado, 4'h2);
    tick(40);
    check("idle40_estado", db_estado, 4'h2);
    tick(20);
`ifdef JOGO_TIMEOUT_EN
    check("timeout_estado", db_estado, 4'hD);
    check("timeout_flags", {db_timeout, perdeu, pronto}, 3'b111);
`else
    check("no_timeout_estado", db_estado, 4'h2);
    check("no_timeout_flags", {db_timeout, perdeu, pronto}, 3'b000);
`endif

    // Asynchronous reset in round 2
    reset = 1'b0; #3 reset = 1'b1;
    tick(1);
    new_game();
    press(4'b0001); press(4'b0001); press(4'b0010);
    check("pre_reset_rodada", db_rodada, 2);
    #3 reset = 1'b0;
    #1;
    check("async_reset_estado", db_estado, 4'h0);
    check("async_reset_outs", {leds, ganhou, perdeu, pronto, db_igual, db_timeout, db_rodada, db_contagem}, 0);
    #2 reset = 1'b1;
    tick(1);
    new_game();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
